// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TAKE    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_VECTOR  = 3'd3,
    ST_HANDLER = 3'd4,
    ST_RETURN  = 3'd5
  } state_t;

  localparam logic [1:0] PC_SEQ     = 2'd0;
  localparam logic [1:0] PC_HANDLER = 2'd1;
  localparam logic [1:0] PC_EPC     = 2'd2;

  // Bit positions inside the one-hot {ovf, unk, ext} cause code.
  localparam int CAUSE_EXT = 0;
  localparam int CAUSE_UNK = 1;
  localparam int CAUSE_OVF = 2;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0010;

endpackage

// File: rtl/exc_sequencer_irq_sync_pend.sv
// One interrupt line: synchronizer chain, rising-edge detect and pending latch.
module irq_sync_pend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic ack,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;

  // Edge-triggered so a level held high across the ack does not re-pend.
  assign rise = sync[SYNC_STAGES-1] & ~prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], irq};
      prev <= sync[SYNC_STAGES-1];
      if (rise) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: prioritizes sync exceptions against latched
// external interrupts and walks the core through take, flush, vector and return.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter int          IRQ_LINES    = 4,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
  parameter int          IDW          = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [IRQ_LINES-1:0] i_irq,
  input  logic [IRQ_LINES-1:0] i_irq_mask,
  input  logic                 i_global_ie,
  input  logic                 i_ovf,
  input  logic                 i_unk_cmd,
  input  logic                 i_unk_func,
  input  logic [31:0]          i_pc,
  input  logic                 i_eret,
  input  logic [31:0]          i_epc,
  output logic                 o_stall,
  output logic                 o_flush,
  output logic [1:0]           o_pc_sel,
  output logic [31:0]          o_pc_target,
  output logic                 o_cop0_take,
  output logic [2:0]           o_cause,
  output logic [31:0]          o_epc_pc,
  output logic [IDW-1:0]       o_irq_id,
  output logic [IRQ_LINES-1:0] o_irq_ack,
  output logic                 o_busy,
  output logic                 o_double_fault,
  output logic [2:0]           o_state
);

  state_t               state;
  state_t               state_next;
  logic [IRQ_LINES-1:0] pending;
  logic [IRQ_LINES-1:0] eligible;
  logic [IRQ_LINES-1:0] ack_r;
  logic [IRQ_LINES-1:0] ack_next;
  logic [IDW-1:0]       id_next;
  logic [IDW-1:0]       id_r;
  logic [2:0]           cause_next;
  logic [2:0]           cause_r;
  logic [31:0]          epc_r;
  logic                 dfault;
  logic                 raw_sync_exc;
  logic                 sync_exc;
  logic                 ext_req;
  logic                 take_now;

  for (genvar g = 0; g < IRQ_LINES; g++) begin : g_line
    irq_sync_pend #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_line (
      .clk    (i_clk),
      .rst    (i_rst),
      .irq    (i_irq[g]),
      .ack    (o_irq_ack[g]),
      .pending(pending[g])
    );
  end

  assign eligible     = pending & i_irq_mask;
  assign raw_sync_exc = i_ovf | i_unk_cmd | i_unk_func;
  assign sync_exc     = i_global_ie & raw_sync_exc;
  assign ext_req      = i_global_ie & (|eligible);
  assign take_now     = (state == ST_IDLE) && (sync_exc || ext_req);

  // Scan downward so the lowest eligible line is the last one written.
  always_comb begin
    id_next  = '0;
    ack_next = '0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        id_next     = IDW'(i);
        ack_next    = '0;
        ack_next[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cause_next = '0;
    if (i_ovf) begin
      cause_next[CAUSE_OVF] = 1'b1;
    end else if (i_unk_cmd || i_unk_func) begin
      cause_next[CAUSE_UNK] = 1'b1;
    end else begin
      cause_next[CAUSE_EXT] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cause_r <= '0;
      id_r    <= '0;
      epc_r   <= '0;
      ack_r   <= '0;
      dfault  <= 1'b0;
    end else begin
      state <= state_next;
      if (take_now) begin
        cause_r <= cause_next;
        epc_r   <= i_pc;
        // A sync exception leaves every pending line untouched.
        id_r    <= sync_exc ? '0 : id_next;
        ack_r   <= sync_exc ? '0 : ack_next;
      end
      if ((state == ST_HANDLER || state == ST_RETURN) && raw_sync_exc) begin
        dfault <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    o_stall     = 1'b0;
    o_flush     = 1'b0;
    o_pc_sel    = PC_SEQ;
    o_pc_target = '0;
    o_cop0_take = 1'b0;
    o_irq_ack   = '0;
    o_busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take_now) state_next = ST_TAKE;
      end
      ST_TAKE: begin
        o_stall     = 1'b1;
        o_cop0_take = 1'b1;
        o_irq_ack   = ack_r;
        state_next  = ST_FLUSH;
      end
      ST_FLUSH: begin
        o_stall    = 1'b1;
        o_flush    = 1'b1;
        state_next = ST_VECTOR;
      end
      ST_VECTOR: begin
        o_pc_sel    = PC_HANDLER;
        o_pc_target = HANDLER_ADDR;
        state_next  = ST_HANDLER;
      end
      ST_HANDLER: begin
        o_busy = 1'b1;
        if (i_eret) state_next = ST_RETURN;
      end
      ST_RETURN: begin
        o_busy      = 1'b1;
        o_pc_sel    = PC_EPC;
        o_pc_target = i_epc;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_cause        = cause_r;
  assign o_irq_id       = id_r;
  assign o_epc_pc       = epc_r;
  assign o_double_fault = dfault;
  assign o_state        = state;

endmodule

// File: tb/tb_exc_sequencer.sv
// Table-driven bench for exc_sequencer with a cycle scoreboard and a few
// hand-written multi-cycle sequences.
module tb_exc_sequencer;
  import exc_pkg::*;

  localparam int          W   = 83;
  localparam logic [31:0] EPC = 32'h0000_0200;
  localparam logic [31:0] HA  = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq = '0;
  logic [3:0]  irq_mask = 4'hF;
  logic        global_ie = 1'b1;
  logic        ovf = 1'b0;
  logic        unk_cmd = 1'b0;
  logic        unk_func = 1'b0;
  logic [31:0] pc = '0;
  logic        eret = 1'b0;
  logic [31:0] epc = EPC;

  logic        o_stall, o_flush, o_cop0_take, o_busy, o_double_fault;
  logic [1:0]  o_pc_sel, o_irq_id;
  logic [31:0] o_pc_target, o_epc_pc;
  logic [2:0]  o_cause, o_state;
  logic [3:0]  o_irq_ack;

  exc_sequencer #(
    .IRQ_LINES(4), .SYNC_STAGES(2), .HANDLER_ADDR(HA)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_irq_mask(irq_mask),
    .i_global_ie(global_ie), .i_ovf(ovf), .i_unk_cmd(unk_cmd),
    .i_unk_func(unk_func), .i_pc(pc), .i_eret(eret), .i_epc(epc),
    .o_stall(o_stall), .o_flush(o_flush), .o_pc_sel(o_pc_sel),
    .o_pc_target(o_pc_target), .o_cop0_take(o_cop0_take), .o_cause(o_cause),
    .o_epc_pc(o_epc_pc), .o_irq_id(o_irq_id), .o_irq_ack(o_irq_ack),
    .o_busy(o_busy), .o_double_fault(o_double_fault), .o_state(o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, ovf, ie, eret;
    logic [1:0]  unk;
    logic [3:0]  irq, mask;
    logic [31:0] pc;
    state_t      ph;
    logic [2:0]  cause;
    logic [31:0] epc_pc;
    logic [1:0]  id;
    logic [3:0]  ack;
    logic        df;
  } vec_t;

  vec_t            tbl[$];
  logic [W-1:0]    exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;

  // Expected outputs for one cycle, from the phase and the held cop0 values.
  function automatic logic [W-1:0] exp_out(state_t ph, logic [2:0] cause,
      logic [31:0] epc_pc, logic [1:0] id, logic [3:0] ack, logic df);
    logic        stall, flush, take, busy;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic [2:0]  st;
    st    = ph;
    stall = (ph == ST_TAKE) || (ph == ST_FLUSH);
    flush = (ph == ST_FLUSH);
    take  = (ph == ST_TAKE);
    busy  = (ph == ST_HANDLER) || (ph == ST_RETURN);
    sel   = (ph == ST_VECTOR) ? 2'd1 : (ph == ST_RETURN) ? 2'd2 : 2'd0;
    tgt   = (ph == ST_VECTOR) ? HA : (ph == ST_RETURN) ? EPC : 32'h0;
    return {st, stall, flush, sel, tgt, take, cause, epc_pc, id, ack, busy, df};
  endfunction

  function automatic logic [W-1:0] got_out();
    return {o_state, o_stall, o_flush, o_pc_sel, o_pc_target, o_cop0_take,
            o_cause, o_epc_pc, o_irq_id, o_irq_ack, o_busy, o_double_fault};
  endfunction

  task automatic add(string name, logic r, logic ov, logic [1:0] un,
      logic [3:0] iq, logic [3:0] mk, logic ie, logic er, logic [31:0] p,
      state_t ph, logic [2:0] cs, logic [31:0] ep, logic [1:0] id,
      logic [3:0] ak, logic df);
    vec_t v;
    v.name = name; v.rst = r; v.ovf = ov; v.unk = un; v.irq = iq; v.mask = mk;
    v.ie = ie; v.eret = er; v.pc = p; v.ph = ph; v.cause = cs; v.epc_pc = ep;
    v.id = id; v.ack = ak; v.df = df;
    tbl.push_back(v);
  endtask

  task automatic check(string name, logic [W-1:0] got);
    logic [W-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h but no expected entry queued", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", name, got, e);
      end
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; ovf = v.ovf; unk_cmd = v.unk[1]; unk_func = v.unk[0];
    irq = v.irq; irq_mask = v.mask; global_ie = v.ie; eret = v.eret; pc = v.pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int takes;

    // name rst ovf unk irq mask ie eret pc | phase cause epc_pc id ack df
    add("reset0",      1,0,2'b00,4'h0,4'hF,1,0,32'h0,   ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("reset1",      1,0,2'b00,4'h0,4'hF,1,0,32'h0,   ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("eret_idle",   0,0,2'b00,4'h0,4'hF,1,1,32'h0,   ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("ovf_sample",  0,1,2'b00,4'h0,4'hF,1,0,32'h40,  ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("ovf_take",    0,0,2'b00,4'h0,4'hF,1,0,32'h40,  ST_TAKE,   3'b100,32'h40, 0,4'h0,0);
    add("ovf_flush",   0,0,2'b00,4'h0,4'hF,1,0,32'h40,  ST_FLUSH,  3'b100,32'h40, 0,4'h0,0);
    add("ovf_vector",  0,0,2'b00,4'h0,4'hF,1,0,32'h10,  ST_VECTOR, 3'b100,32'h40, 0,4'h0,0);
    add("ovf_handler", 0,0,2'b00,4'h0,4'hF,1,0,32'h10,  ST_HANDLER,3'b100,32'h40, 0,4'h0,0);
    add("ovf_eret",    0,0,2'b00,4'h0,4'hF,1,1,32'h14,  ST_HANDLER,3'b100,32'h40, 0,4'h0,0);
    add("ovf_return",  0,0,2'b00,4'h0,4'hF,1,0,32'h14,  ST_RETURN, 3'b100,32'h40, 0,4'h0,0);
    add("ovf_idle",    0,0,2'b00,4'h0,4'hF,1,0,32'h80,  ST_IDLE,   3'b100,32'h40, 0,4'h0,0);
    add("irq21_rise",  0,0,2'b00,4'h6,4'hF,1,0,32'h80,  ST_IDLE,   3'b100,32'h40, 0,4'h0,0);
    add("irq21_s1",    0,0,2'b00,4'h6,4'hF,1,0,32'h80,  ST_IDLE,   3'b100,32'h40, 0,4'h0,0);
    add("irq21_s2",    0,0,2'b00,4'h6,4'hF,1,0,32'h80,  ST_IDLE,   3'b100,32'h40, 0,4'h0,0);
    add("irq21_pend",  0,0,2'b00,4'h6,4'hF,1,0,32'h80,  ST_IDLE,   3'b100,32'h40, 0,4'h0,0);
    add("irq1_take",   0,0,2'b00,4'h6,4'hF,1,0,32'h80,  ST_TAKE,   3'b001,32'h80, 1,4'h2,0);
    add("irq1_flush",  0,0,2'b00,4'h6,4'hF,1,0,32'h80,  ST_FLUSH,  3'b001,32'h80, 1,4'h0,0);
    add("irq1_vector", 0,0,2'b00,4'h6,4'hF,1,0,32'h10,  ST_VECTOR, 3'b001,32'h80, 1,4'h0,0);
    add("irq1_eret",   0,0,2'b00,4'h6,4'hF,1,1,32'h10,  ST_HANDLER,3'b001,32'h80, 1,4'h0,0);
    add("irq1_return", 0,0,2'b00,4'h6,4'hF,1,0,32'h14,  ST_RETURN, 3'b001,32'h80, 1,4'h0,0);
    add("irq1_gap",    0,0,2'b00,4'h6,4'hF,1,0,32'h200, ST_IDLE,   3'b001,32'h80, 1,4'h0,0);
    add("irq2_take",   0,0,2'b00,4'h6,4'hF,1,0,32'h200, ST_TAKE,   3'b001,32'h200,2,4'h4,0);
    add("irq2_flush",  0,0,2'b00,4'h6,4'hF,1,0,32'h200, ST_FLUSH,  3'b001,32'h200,2,4'h0,0);
    add("irq2_vector", 0,0,2'b00,4'h6,4'hF,1,0,32'h10,  ST_VECTOR, 3'b001,32'h200,2,4'h0,0);
    add("irq2_eret",   0,0,2'b00,4'h6,4'hF,1,1,32'h10,  ST_HANDLER,3'b001,32'h200,2,4'h0,0);
    add("irq2_return", 0,0,2'b00,4'h6,4'hF,1,0,32'h14,  ST_RETURN, 3'b001,32'h200,2,4'h0,0);
    add("held_idle",   0,0,2'b00,4'h6,4'hF,1,0,32'h200, ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("irq_drop",    0,0,2'b00,4'h0,4'hF,1,0,32'h204, ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("no_repend",   0,0,2'b00,4'h0,4'hF,1,0,32'h208, ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("mask_rise",   0,0,2'b00,4'h8,4'h7,1,0,32'hC0,  ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("mask_s1",     0,0,2'b00,4'h8,4'h7,1,0,32'hC0,  ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("mask_s2",     0,0,2'b00,4'h8,4'h7,1,0,32'hC0,  ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("mask_pend",   0,0,2'b00,4'h8,4'h7,1,0,32'hC0,  ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("mask_hold",   0,0,2'b00,4'h8,4'h7,1,0,32'hC0,  ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("unmask",      0,0,2'b00,4'h8,4'hF,1,0,32'hC0,  ST_IDLE,   3'b001,32'h200,2,4'h0,0);
    add("irq3_take",   0,0,2'b00,4'h8,4'hF,1,0,32'hC0,  ST_TAKE,   3'b001,32'hC0, 3,4'h8,0);
    add("irq3_flush",  0,0,2'b00,4'h8,4'hF,1,0,32'hC0,  ST_FLUSH,  3'b001,32'hC0, 3,4'h0,0);
    add("irq3_vector", 0,0,2'b00,4'h8,4'hF,1,0,32'h10,  ST_VECTOR, 3'b001,32'hC0, 3,4'h0,0);
    add("irq3_eret",   0,0,2'b00,4'h8,4'hF,1,1,32'h10,  ST_HANDLER,3'b001,32'hC0, 3,4'h0,0);
    add("irq3_return", 0,0,2'b00,4'h8,4'hF,1,0,32'h14,  ST_RETURN, 3'b001,32'hC0, 3,4'h0,0);
    add("irq3_idle",   0,0,2'b00,4'h0,4'hF,1,0,32'h100, ST_IDLE,   3'b001,32'hC0, 3,4'h0,0);
    add("unk_rise",    0,0,2'b00,4'h1,4'hF,1,0,32'h100, ST_IDLE,   3'b001,32'hC0, 3,4'h0,0);
    add("unk_s1",      0,0,2'b00,4'h1,4'hF,1,0,32'h100, ST_IDLE,   3'b001,32'hC0, 3,4'h0,0);
    add("unk_s2",      0,0,2'b00,4'h1,4'hF,1,0,32'h100, ST_IDLE,   3'b001,32'hC0, 3,4'h0,0);
    add("unk_coinc",   0,0,2'b01,4'h1,4'hF,1,0,32'h100, ST_IDLE,   3'b001,32'hC0, 3,4'h0,0);
    add("unk_take",    0,0,2'b00,4'h1,4'hF,1,0,32'h100, ST_TAKE,   3'b010,32'h100,0,4'h0,0);
    add("unk_flush",   0,0,2'b00,4'h1,4'hF,1,0,32'h100, ST_FLUSH,  3'b010,32'h100,0,4'h0,0);
    add("unk_vector",  0,0,2'b00,4'h1,4'hF,1,0,32'h10,  ST_VECTOR, 3'b010,32'h100,0,4'h0,0);
    add("unk_eret",    0,0,2'b00,4'h1,4'hF,1,1,32'h10,  ST_HANDLER,3'b010,32'h100,0,4'h0,0);
    add("unk_return",  0,0,2'b00,4'h1,4'hF,1,0,32'h14,  ST_RETURN, 3'b010,32'h100,0,4'h0,0);
    add("unk_gap",     0,0,2'b00,4'h1,4'hF,1,0,32'h200, ST_IDLE,   3'b010,32'h100,0,4'h0,0);
    add("irq0_take",   0,0,2'b00,4'h1,4'hF,1,0,32'h200, ST_TAKE,   3'b001,32'h200,0,4'h1,0);
    add("irq0_flush",  0,0,2'b00,4'h1,4'hF,1,0,32'h200, ST_FLUSH,  3'b001,32'h200,0,4'h0,0);
    add("irq0_vector", 0,0,2'b00,4'h1,4'hF,1,0,32'h10,  ST_VECTOR, 3'b001,32'h200,0,4'h0,0);
    add("df_ovf",      0,1,2'b00,4'h1,4'hF,1,0,32'h10,  ST_HANDLER,3'b001,32'h200,0,4'h0,0);
    add("df_set",      0,0,2'b00,4'h1,4'hF,1,0,32'h14,  ST_HANDLER,3'b001,32'h200,0,4'h0,1);
    add("df_hold",     0,0,2'b00,4'h1,4'hF,1,0,32'h18,  ST_HANDLER,3'b001,32'h200,0,4'h0,1);
    add("df_eret",     0,0,2'b00,4'h1,4'hF,1,1,32'h1C,  ST_HANDLER,3'b001,32'h200,0,4'h0,1);
    add("df_return",   0,0,2'b00,4'h1,4'hF,1,0,32'h20,  ST_RETURN, 3'b001,32'h200,0,4'h0,1);
    add("df_idle",     0,0,2'b00,4'h0,4'hF,1,0,32'h200, ST_IDLE,   3'b001,32'h200,0,4'h0,1);
    add("rstf_rise",   0,0,2'b00,4'h4,4'h0,1,0,32'h300, ST_IDLE,   3'b001,32'h200,0,4'h0,1);
    add("rstf_ovf",    0,1,2'b00,4'h4,4'h0,1,0,32'h300, ST_IDLE,   3'b001,32'h200,0,4'h0,1);
    add("rstf_take",   0,0,2'b00,4'h4,4'h0,1,0,32'h300, ST_TAKE,   3'b100,32'h300,0,4'h0,1);
    add("rstf_flush",  1,0,2'b00,4'h0,4'h0,1,0,32'h300, ST_FLUSH,  3'b100,32'h300,0,4'h0,1);
    add("rstf_after",  0,0,2'b00,4'h0,4'hF,1,0,32'h300, ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("rstf_quiet",  0,0,2'b00,4'h0,4'hF,1,0,32'h304, ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("rstf_quiet2", 0,0,2'b00,4'h0,4'hF,1,0,32'h308, ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("ie_off",      0,1,2'b11,4'h0,4'hF,0,0,32'h30C, ST_IDLE,   3'b000,32'h0,  0,4'h0,0);
    add("ie_off2",     0,0,2'b00,4'h0,4'hF,0,0,32'h310, ST_IDLE,   3'b000,32'h0,  0,4'h0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      exp_q.push_back(exp_out(tbl[i].ph, tbl[i].cause, tbl[i].epc_pc,
                              tbl[i].id, tbl[i].ack, tbl[i].df));
      @(negedge clk);
      check(tbl[i].name, got_out());
    end

    // Line 1 held high: one take, then no re-take after the handler returns.
    @(posedge clk); #1;
    global_ie = 1'b1; irq_mask = 4'hF; ovf = 1'b0; unk_cmd = 1'b0; unk_func = 1'b0;
    pc = 32'h400; irq = 4'h2;
    exp_q.push_back(exp_out(ST_TAKE, 3'b001, 32'h400, 2'd1, 4'h2, 1'b0));
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (o_cop0_take) begin
        found = 1'b1;
        check("ext_wait_take", got_out());
      end
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL ext_wait_take: cop0_take got 0 required 1 within 12 cycles");
      exp_q.delete();
    end

    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (o_state == ST_HANDLER) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reach_handler: state got %0d required %0d", o_state, ST_HANDLER);
    end
    @(posedge clk); #1; eret = 1'b1;
    @(posedge clk); #1; eret = 1'b0;
    takes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_cop0_take) takes++;
    end
    n_vec++;
    if (takes != 0) begin
      n_err++;
      $display("FAIL held_line_retake: takes got %0d required 0", takes);
    end
    n_vec++;
    if (o_state !== ST_IDLE || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL final_idle: state/busy got %0d/%0b required %0d/0", o_state, o_busy, ST_IDLE);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: leftover got %0d required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
